// File: rtl/fc_stream_engine.sv
// Streaming int8 fully-connected layer: buffer one feature vector, then per neuron
// take a bias beat plus weight beats, MAC across lanes and emit a 32-bit result.
module fc_lane (
  input  logic signed [7:0]  feat,
  input  logic signed [7:0]  wt,
  output logic signed [15:0] prod
);
  assign prod = 16'(feat) * 16'(wt);
endmodule

module fc_stream_engine #(
  parameter  int C_AXIS_TDATA_WIDTH = 32,
  parameter  int MAX_IN_BEATS       = 256,
  parameter  int MAX_OUT            = 16,
  localparam int NUM_LANES = C_AXIS_TDATA_WIDTH / 8,
  localparam int IDX_W     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  localparam int OUT_W     = IDX_W + 1,
  localparam int BEAT_W    = $clog2(MAX_IN_BEATS) + 1,
  localparam int ADDR_W    = (MAX_IN_BEATS > 1) ? $clog2(MAX_IN_BEATS) : 1
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          start,
  input  logic [BEAT_W-1:0]             cfg_in_beats,
  input  logic [OUT_W-1:0]              cfg_out_len,
  input  logic                          cfg_relu,
  output logic                          S_AXIS_TREADY,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  output logic                          busy,
  output logic                          fc_done,
  output logic [IDX_W-1:0]              max_index,
  output logic [31:0]                   max_value,
  output logic [31:0]                   clk_counter
);
  typedef enum logic [2:0] {IDLE, LOAD_FEAT, BIAS, MAC, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [BEAT_W-1:0]             in_beats_q, beat_cnt;
  logic [OUT_W-1:0]              out_len_q, neuron_cnt;
  logic                          relu_q;
  logic signed [31:0]            acc, dot;
  logic [31:0]                   result;
  logic [NUM_LANES-1:0][7:0]     feat_mem [MAX_IN_BEATS];
  logic [NUM_LANES-1:0][7:0]     feat_rd, wt_lanes;
  logic [NUM_LANES-1:0][15:0]    prod;
  logic                          cfg_ok, start_ok, s_hs, m_hs, beat_last, neuron_last;
  logic                          unused_tlast;

  assign unused_tlast = S_AXIS_TLAST;

  assign cfg_ok   = (cfg_in_beats != '0) && (cfg_in_beats <= BEAT_W'(MAX_IN_BEATS)) &&
                    (cfg_out_len != '0) && (cfg_out_len <= OUT_W'(MAX_OUT));
  assign start_ok = (state == IDLE) && start && cfg_ok;

  assign S_AXIS_TREADY = (state == LOAD_FEAT) || (state == BIAS) || (state == MAC);
  assign M_AXIS_TVALID = (state == EMIT);
  assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_hs          = M_AXIS_TVALID && M_AXIS_TREADY;
  assign beat_last     = (beat_cnt == in_beats_q - BEAT_W'(1));
  assign neuron_last   = (neuron_cnt == out_len_q - OUT_W'(1));

  assign result        = (relu_q && acc[31]) ? 32'd0 : acc;
  assign M_AXIS_TDATA  = (state == EMIT) ? result : 32'd0;
  assign M_AXIS_TLAST  = (state == EMIT) && neuron_last;
  assign busy          = (state != IDLE);
  assign fc_done       = (state == DONE);

  // Feature row for the current weight beat; lanes multiply in parallel.
  assign feat_rd  = feat_mem[beat_cnt[ADDR_W-1:0]];
  assign wt_lanes = S_AXIS_TDATA;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    fc_lane u_lane (.feat(feat_rd[j]), .wt(wt_lanes[j]), .prod(prod[j]));
  end

  always_comb begin
    dot = '0;
    for (int j = 0; j < NUM_LANES; j++) dot = dot + 32'($signed(prod[j]));
  end

  // Feature buffer has no reset so a vector survives between runs.
  always_ff @(posedge CLK)
    if (state == LOAD_FEAT && s_hs) feat_mem[beat_cnt[ADDR_W-1:0]] <= S_AXIS_TDATA;

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = LOAD_FEAT;
      LOAD_FEAT: if (s_hs && beat_last) state_nxt = BIAS;
      BIAS:      if (s_hs) state_nxt = MAC;
      MAC:       if (s_hs && beat_last) state_nxt = EMIT;
      EMIT:      if (m_hs) state_nxt = neuron_last ? DONE : BIAS;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      in_beats_q  <= '0;
      out_len_q   <= '0;
      relu_q      <= 1'b0;
      beat_cnt    <= '0;
      neuron_cnt  <= '0;
      acc         <= '0;
      max_index   <= '0;
      max_value   <= '0;
      clk_counter <= '0;
    end else begin
      if (start_ok) begin
        in_beats_q  <= cfg_in_beats;
        out_len_q   <= cfg_out_len;
        relu_q      <= cfg_relu;
        beat_cnt    <= '0;
        neuron_cnt  <= '0;
        clk_counter <= '0;
      end else if (busy) begin
        clk_counter <= clk_counter + 32'd1;
      end
      case (state)
        LOAD_FEAT: if (s_hs) beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
        BIAS:      if (s_hs) acc <= $signed(S_AXIS_TDATA[31:0]);
        MAC: if (s_hs) begin
          acc      <= acc + dot;
          beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
        end
        EMIT: if (m_hs) begin
          neuron_cnt <= neuron_cnt + OUT_W'(1);
          // Strict compare: ties keep the earliest neuron.
          if (neuron_cnt == '0 || $signed(result) > $signed(max_value)) begin
            max_index <= neuron_cnt[IDX_W-1:0];
            max_value <= result;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fc_stream_engine.sv
// Bench for fc_stream_engine: table of runs with constant expected outputs fed through
// a scoreboard queue, plus hand sequences for bounds and mid-run reset.
`timescale 1ns/1ps
module tb_fc_stream_engine;
  logic        CLK = 1'b0, RESETN = 1'b0, start = 1'b0, cfg_relu = 1'b0;
  logic [8:0]  cfg_in_beats = '0;
  logic [4:0]  cfg_out_len = '0;
  logic        S_AXIS_TREADY, S_AXIS_TVALID = 1'b0, S_AXIS_TLAST = 1'b0;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        M_AXIS_TREADY = 1'b0, M_AXIS_TVALID, M_AXIS_TLAST;
  logic [31:0] M_AXIS_TDATA, max_value, clk_counter;
  logic        busy, fc_done;
  logic [3:0]  max_index;

  fc_stream_engine #(.C_AXIS_TDATA_WIDTH(32), .MAX_IN_BEATS(256), .MAX_OUT(16)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .cfg_in_beats(cfg_in_beats),
    .cfg_out_len(cfg_out_len), .cfg_relu(cfg_relu), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .busy(busy), .fc_done(fc_done), .max_index(max_index),
    .max_value(max_value), .clk_counter(clk_counter));

  always #5 CLK = ~CLK;

  typedef struct {
    int                    nb, no, gap, rstall, exp_idx, exp_cyc;
    bit                    relu, mid;
    logic [1:0][31:0]      feat;
    logic [2:0][31:0]      bias;
    logic [2:0][1:0][31:0] wt;
    logic [2:0][31:0]      exp_o;
    logic [31:0]           exp_val;
  } vec_t;

  vec_t        v [5];
  logic [32:0] sb [$];
  int          n_cmp = 0, n_err = 0, done_cnt = 0;
  bit          mid_pulse = 1'b0;

  always @(negedge CLK) if (fc_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap);
    int t;
    repeat (gap) begin @(negedge CLK); start = 1'b0; S_AXIS_TVALID = 1'b0; end
    t = 0;
    forever begin
      @(negedge CLK);
      start = 1'b0;
      if (mid_pulse) begin start = 1'b1; cfg_in_beats = 9'd3; cfg_out_len = 5'd1; mid_pulse = 1'b0; end
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = d;
      if (S_AXIS_TREADY) break;
      t++;
      if (t > 500) begin n_cmp++; n_err++; $display("FAIL s_timeout: got no TREADY want TREADY"); break; end
    end
  endtask

  task automatic drive(input vec_t x);
    for (int k = 0; k < x.nb; k++) send_beat(x.feat[k], x.gap);
    for (int n = 0; n < x.no; n++) begin
      if (x.mid && n == 0) mid_pulse = 1'b1;
      send_beat(x.bias[n], 0);
      for (int k = 0; k < x.nb; k++) begin
        if (k == x.nb - 1) sb.push_back({n == x.no - 1, x.exp_o[n]});
        send_beat(x.wt[n][k], x.gap);
      end
    end
    @(negedge CLK); S_AXIS_TVALID = 1'b0;
  endtask

  task automatic sink(input int no, input int rstall);
    int got, stall, t;
    logic [32:0] e;
    got = 0; stall = rstall; t = 0;
    while (got < no) begin
      @(negedge CLK);
      M_AXIS_TREADY = 1'b0;
      if (M_AXIS_TVALID) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++; got++;
          $display("FAIL sb_empty: got tdata %h want no output", M_AXIS_TDATA);
          M_AXIS_TREADY = 1'b1;
        end else begin
          e = sb[0];
          chk("tdata", M_AXIS_TDATA, e[31:0]);
          if (stall > 0) stall--;
          else begin
            chk("tlast", M_AXIS_TLAST, e[32]);
            void'(sb.pop_front());
            M_AXIS_TREADY = 1'b1;
            got++;
            stall = rstall;
          end
        end
      end
      t++;
      if (t > 3000) begin n_cmp++; n_err++; $display("FAIL m_timeout: got %0d outputs want %0d", got, no); break; end
    end
  endtask

  task automatic do_run(input vec_t x);
    int d0;
    d0 = done_cnt;
    @(negedge CLK);
    cfg_in_beats = 9'(x.nb); cfg_out_len = 5'(x.no); cfg_relu = x.relu; start = 1'b1;
    fork
      drive(x);
      sink(x.no, x.rstall);
    join
    @(negedge CLK);
    M_AXIS_TREADY = 1'b0;
    chk("fc_done", fc_done, 1);
    @(negedge CLK);
    chk("busy_end", busy, 0);
    chk("clk_counter", clk_counter, x.exp_cyc);
    chk("max_index", max_index, x.exp_idx);
    chk("max_value", max_value, x.exp_val);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_tready"}, S_AXIS_TREADY, 0);
    chk({tag, "_m_tvalid"}, M_AXIS_TVALID, 0);
    chk({tag, "_m_tlast"}, M_AXIS_TLAST, 0);
    chk({tag, "_m_tdata"}, M_AXIS_TDATA, 0);
    chk({tag, "_fc_done"}, fc_done, 0);
    chk({tag, "_max_index"}, max_index, 0);
    chk({tag, "_max_value"}, max_value, 0);
    chk({tag, "_clk_counter"}, clk_counter, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // basic run: features {1,2,3,4}; 10+1+2+3+4=20, -5+2=-3
    v[0].nb = 1; v[0].no = 2; v[0].relu = 0; v[0].gap = 0; v[0].rstall = 0; v[0].mid = 0;
    v[0].feat[0] = 32'h04030201;
    v[0].bias[0] = 32'd10;        v[0].wt[0][0] = 32'h01010101;
    v[0].bias[1] = 32'hFFFFFFFB;  v[0].wt[1][0] = 32'h00000002;
    v[0].exp_o[0] = 32'd20;       v[0].exp_o[1] = 32'hFFFFFFFD;
    v[0].exp_idx = 0; v[0].exp_val = 32'd20; v[0].exp_cyc = 8;
    // relu + ties: raw -7, 0, 0 -> all 0, first index wins
    v[1].nb = 1; v[1].no = 3; v[1].relu = 1; v[1].gap = 0; v[1].rstall = 0; v[1].mid = 0;
    v[1].feat[0] = 32'h04030201;
    v[1].bias[0] = 32'hFFFFFFF9;  v[1].wt[0][0] = 32'h0;
    v[1].bias[1] = 32'h0;         v[1].wt[1][0] = 32'h0;
    v[1].bias[2] = 32'hFFFFFFFE;  v[1].wt[2][0] = 32'h00000002;
    v[1].exp_o[0] = 0; v[1].exp_o[1] = 0; v[1].exp_o[2] = 0;
    v[1].exp_idx = 0; v[1].exp_val = 0; v[1].exp_cyc = 11;
    // wrap: 0x7FFFFFFF + 1
    v[2].nb = 1; v[2].no = 1; v[2].relu = 0; v[2].gap = 0; v[2].rstall = 0; v[2].mid = 0;
    v[2].feat[0] = 32'h04030201;
    v[2].bias[0] = 32'h7FFFFFFF;  v[2].wt[0][0] = 32'h00000001;
    v[2].exp_o[0] = 32'h80000000;
    v[2].exp_idx = 0; v[2].exp_val = 32'h80000000; v[2].exp_cyc = 5;
    // backpressure + mid-run start: same data as basic, 8 + 9 input gaps + 10 output stalls
    v[3] = v[0];
    v[3].gap = 3; v[3].rstall = 5; v[3].mid = 1; v[3].exp_cyc = 27;
    // two beats, negative features, tie between neurons 1 and 2
    v[4].nb = 2; v[4].no = 3; v[4].relu = 0; v[4].gap = 1; v[4].rstall = 2; v[4].mid = 0;
    v[4].feat[0] = 32'h04FD02FF;  v[4].feat[1] = 32'h0005807F;
    v[4].bias[0] = 32'd100; v[4].wt[0][0] = 32'h01010101; v[4].wt[0][1] = 32'h01010101;
    v[4].bias[1] = 32'd0;   v[4].wt[1][0] = 32'h80808080; v[4].wt[1][1] = 32'h7F7F7F7F;
    v[4].bias[2] = 32'd252; v[4].wt[2][0] = 32'h0;        v[4].wt[2][1] = 32'h0;
    v[4].exp_o[0] = 32'd106; v[4].exp_o[1] = 32'd252; v[4].exp_o[2] = 32'd252;
    v[4].exp_idx = 1; v[4].exp_val = 32'd252; v[4].exp_cyc = 29;

    repeat (2) @(negedge CLK);
    chk_zero("rst");
    RESETN = 1'b1;

    // rejected starts
    @(negedge CLK); cfg_in_beats = 9'd0; cfg_out_len = 5'd2; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("bound_nb0_busy", busy, 0);
    chk("bound_nb0_tready", S_AXIS_TREADY, 0);
    cfg_in_beats = 9'd1; cfg_out_len = 5'd17; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("bound_out17_busy", busy, 0);
    cfg_in_beats = 9'd257; cfg_out_len = 5'd1; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("bound_nb257_busy", busy, 0);

    for (int i = 0; i < 5; i++) do_run(v[i]);

    // reset during MAC: abandon run, all outputs clear at once
    d0 = done_cnt;
    @(negedge CLK); cfg_in_beats = 9'd2; cfg_out_len = 5'd1; cfg_relu = 1'b0; start = 1'b1;
    send_beat(32'h01010101, 0);
    send_beat(32'h01010101, 0);
    send_beat(32'd5, 0);
    send_beat(32'h01010101, 0);
    @(negedge CLK); S_AXIS_TVALID = 1'b0;
    chk("mid_busy", busy, 1);
    RESETN = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_no_done", done_cnt - d0, 0);

    do_run(v[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
